// File: rtl/branch_ctrl.sv
// branch_ctrl: ID-stage branch hazard stall and registered redirect sequencer (optional stats via BRANCH_CTRL_STAT_EN)
module branch_ctrl #(
  parameter int ADDR_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              id_is_branch,
  input  logic              id_rs1_re,
  input  logic              id_rs2_re,
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic [REG_AW-1:0] id_rs2_addr,
  input  logic              ex_rd_we,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_rd_addr,
  input  logic              mem_rd_we,
  input  logic              mem_is_load,
  input  logic [REG_AW-1:0] mem_rd_addr,
  input  logic              bu_pc_we,
  input  logic [ADDR_W-1:0] bu_pc,
  output logic              stall_o,
  output logic              bubble_o,
  output logic              flush_o,
  output logic              redirect_we_o,
  output logic [ADDR_W-1:0] redirect_pc_o,
  output logic [31:0]       stat_branch_o,
  output logic [31:0]       stat_taken_o,
  output logic [31:0]       stat_stall_o
);
  localparam logic [1:0] IDLE = 2'd0, STALL = 2'd1, REDIRECT = 2'd2;
  logic [1:0] state, cnt, n;
  logic qual, ex_m, mem_m, idle;
  always_comb begin
    qual = id_valid & id_is_branch;
    ex_m = ex_rd_we && ((id_rs1_re && id_rs1_addr != '0 && ex_rd_addr == id_rs1_addr) ||
                        (id_rs2_re && id_rs2_addr != '0 && ex_rd_addr == id_rs2_addr));
    mem_m = mem_rd_we && ((id_rs1_re && id_rs1_addr != '0 && mem_rd_addr == id_rs1_addr) ||
                          (id_rs2_re && id_rs2_addr != '0 && mem_rd_addr == id_rs2_addr));
    n = !qual ? 2'd0 : ex_m ? (ex_is_load ? 2'd2 : 2'd1) : (mem_m && mem_is_load) ? 2'd1 : 2'd0;
    idle = state == IDLE && !rst;
    stall_o = (idle && n != 2'd0) || (state == STALL && !rst);
    bubble_o = stall_o;
    flush_o = (idle && n == 2'd0 && bu_pc_we) || (state == REDIRECT && !rst);
    redirect_we_o = state == REDIRECT && !rst;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      redirect_pc_o <= '0;
    end else if (state == IDLE) begin
      if (n != 2'd0) begin
        cnt <= n - 2'd1;
        state <= (n == 2'd2) ? STALL : IDLE;
      end else if (bu_pc_we) begin
        redirect_pc_o <= bu_pc;
        state <= REDIRECT;
      end
    end else if (state == STALL) begin
      cnt <= cnt - 2'd1;
      state <= (cnt == 2'd1) ? IDLE : STALL;
    end else begin
      state <= IDLE;
    end
  end
`ifdef BRANCH_CTRL_STAT_EN
  logic br_inc, tk_inc;
  always_comb begin
    br_inc = idle && n == 2'd0 && qual;
    tk_inc = idle && n == 2'd0 && bu_pc_we;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branch_o <= '0;
      stat_taken_o <= '0;
      stat_stall_o <= '0;
    end else begin
      if (br_inc && stat_branch_o != '1) stat_branch_o <= stat_branch_o + 32'd1;
      if (tk_inc && stat_taken_o != '1) stat_taken_o <= stat_taken_o + 32'd1;
      if (stall_o && stat_stall_o != '1) stat_stall_o <= stat_stall_o + 32'd1;
    end
  end
`else
  assign stat_branch_o = '0;
  assign stat_taken_o = '0;
  assign stat_stall_o = '0;
`endif
endmodule
